// File: rtl/sseg_scan_pkg.sv
// Shared types and constants for the 4-digit multiplexed 7-segment driver.
package sseg_scan_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    localparam int         NUM_DIGITS = 4;
    localparam logic [3:0] AN_OFF     = 4'b1111;
    localparam logic [7:0] SEG_OFF    = 8'hFF;

    // Active-low one-hot anode select for a digit index.
    function automatic logic [3:0] anode_for(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/sseg_refresh_timer.sv
// Slot counter and digit sequencer: wraps every 2^REFRESH_BITS cycles,
// advances digit_idx on each wrap and pulses frame_tick during digit 3's last cycle.
module sseg_refresh_timer
    import sseg_scan_pkg::*;
#(
    parameter int REFRESH_BITS = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    output logic [REFRESH_BITS-1:0] cnt,
    output logic [1:0]              digit_idx,
    output logic                    wrap,
    output logic                    frame_tick
);

    localparam logic [REFRESH_BITS-1:0] PRE_WRAP   = {{(REFRESH_BITS-1){1'b1}}, 1'b0};
    localparam logic [1:0]              LAST_DIGIT = 2'(NUM_DIGITS - 1);

    assign wrap = (cnt == '1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            digit_idx  <= '0;
            frame_tick <= 1'b0;
        end else begin
            cnt <= cnt + REFRESH_BITS'(1);
            if (wrap) begin
                digit_idx <= digit_idx + 2'd1;
            end
            // Registered one cycle early so the pulse coincides with the wrap cycle.
            frame_tick <= (cnt == PRE_WRAP) && (digit_idx == LAST_DIGIT);
        end
    end

endmodule

// File: rtl/sseg_scan_mux.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with inter-digit blanking.
// Optional macro SSEG_SCAN_DIM_EN adds a 4-bit duty input that shortens the lit phase.
module sseg_scan_mux
    import sseg_scan_pkg::*;
#(
    parameter int REFRESH_BITS = 16,
    parameter int BLANK_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [7:0] sseg0,
    input  logic [7:0] sseg1,
    input  logic [7:0] sseg2,
    input  logic [7:0] sseg3,
`ifdef SSEG_SCAN_DIM_EN
    input  logic [3:0] duty,
`endif
    output logic [3:0] an,
    output logic [7:0] sseg,
    output logic [1:0] digit_idx,
    output logic       frame_tick
);

    localparam logic [REFRESH_BITS-1:0] BLANK_LAST = REFRESH_BITS'(BLANK_CYCLES - 1);

    logic [REFRESH_BITS-1:0] cnt;
    logic                    wrap;
    state_t                  state_q, state_d;
    logic [7:0]              pat_q, pat_d;
    logic [7:0]              sel_pat, seg_src;
    logic [3:0]              an_d;
    logic [7:0]              seg_d;
    logic                    lit, capture, gate;

    sseg_refresh_timer #(
        .REFRESH_BITS (REFRESH_BITS)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .cnt        (cnt),
        .digit_idx  (digit_idx),
        .wrap       (wrap),
        .frame_tick (frame_tick)
    );

    always_comb begin
        sel_pat = sseg0;
        case (digit_idx)
            2'd0:    sel_pat = sseg0;
            2'd1:    sel_pat = sseg1;
            2'd2:    sel_pat = sseg2;
            default: sel_pat = sseg3;
        endcase
    end

`ifdef SSEG_SCAN_DIM_EN
    logic [3:0]              duty_q, duty_d;
    logic [REFRESH_BITS-1:0] cnt_next;

    assign cnt_next = cnt + REFRESH_BITS'(1);
`endif

    // Outputs are computed for the cycle after the edge, so the first lit
    // cycle is the one where cnt == BLANK_CYCLES.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        seg_src = pat_q;
        lit     = 1'b0;
        capture = 1'b0;
        case (state_q)
            ST_BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_d = ST_DRIVE;
                    capture = 1'b1;
                    pat_d   = sel_pat;
                    seg_src = sel_pat;
                    lit     = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (wrap) begin
                    state_d = ST_BLANK;
                end else begin
                    lit = 1'b1;
                end
            end
            default: state_d = ST_BLANK;
        endcase

`ifdef SSEG_SCAN_DIM_EN
        duty_d = capture ? duty : duty_q;
        gate   = (cnt_next[REFRESH_BITS-1 -: 4] <= duty_d);
`else
        gate   = capture | ~capture;
`endif

        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        if (lit && en && gate) begin
            an_d  = anode_for(digit_idx);
            seg_d = seg_src;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pat_q <= SEG_OFF;
            an    <= AN_OFF;
            sseg  <= SEG_OFF;
        end else begin
            pat_q <= pat_d;
            an    <= an_d;
            sseg  <= seg_d;
        end
    end

`ifdef SSEG_SCAN_DIM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_q <= '1;
        end else begin
            duty_q <= duty_d;
        end
    end
`endif

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Self-checking bench for sseg_scan_mux (REFRESH_BITS=4, BLANK_CYCLES=2).
// Define SSEG_SCAN_DIM_EN to also exercise the duty input.
module tb_sseg_scan_mux;

    localparam int RB   = 4;
    localparam int BC   = 2;
    localparam int SLOT = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b1;
    logic [7:0] s0 = 8'hC0, s1 = 8'hF9, s2 = 8'hA4, s3 = 8'hB0;
    logic [3:0] an;
    logic [7:0] sseg;
    logic [1:0] digit_idx;
    logic       frame_tick;
`ifdef SSEG_SCAN_DIM_EN
    logic [3:0] duty = 4'd15;
`endif

    sseg_scan_mux #(
        .REFRESH_BITS (RB),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .sseg0      (s0),
        .sseg1      (s1),
        .sseg2      (s2),
        .sseg3      (s3),
`ifdef SSEG_SCAN_DIM_EN
        .duty       (duty),
`endif
        .an         (an),
        .sseg       (sseg),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: k = clock edges since reset release.
    int         k = 0;
    logic [7:0] lat_pat = 8'hFF;
    int         duty_lat = 15;
    logic       en_edge = 1'b1;
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    logic [1:0] exp_digit;
    logic       exp_ft;

    function automatic logic [7:0] pat_of(input int d);
        case (d)
            0:       return s0;
            1:       return s1;
            2:       return s2;
            default: return s3;
        endcase
    endfunction

    // Called at a falling edge; advances one clock and refreshes the expectations.
    task automatic tick();
        int  c, d;
        logic lit;
        c = k % SLOT;
        d = (k / SLOT) % 4;
        if (c == BC - 1) begin
            lat_pat = pat_of(d);
`ifdef SSEG_SCAN_DIM_EN
            duty_lat = int'(duty);
`else
            duty_lat = 15;
`endif
        end
        en_edge = en;
        @(posedge clk);
        k++;
        @(negedge clk);
        c = k % SLOT;
        d = (k / SLOT) % 4;
        lit = en_edge && (c >= BC) && (c <= duty_lat);
        exp_an    = lit ? ~(4'b0001 << d) : 4'b1111;
        exp_seg   = lit ? lat_pat : 8'hFF;
        exp_digit = 2'(d);
        exp_ft    = (c == SLOT - 1) && (d == 3);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        k = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        @(negedge clk);
        checks++; if (an !== 4'b1111) begin failures++; $display("FAIL reset_an got=%b exp=1111", an); end
        checks++; if (sseg !== 8'hFF) begin failures++; $display("FAIL reset_sseg got=%h exp=ff", sseg); end
        checks++; if (digit_idx !== 2'd0) begin failures++; $display("FAIL reset_digit got=%0d exp=0", digit_idx); end
        checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL reset_ft got=%b exp=0", frame_tick); end
        reset_n = 1'b1;
        k = 0;
    endtask

    task automatic test_scan();
        int ft_count = 0;
        s0 = 8'hC0; s1 = 8'hF9; s2 = 8'hA4; s3 = 8'hB0; en = 1'b1;
        do_reset();
        for (int i = 0; i < 128; i++) begin
            tick();
            if (frame_tick === 1'b1) ft_count++;
            checks++; if (an !== exp_an) begin failures++; $display("FAIL scan_an k=%0d got=%b exp=%b", k, an, exp_an); end
            checks++; if (sseg !== exp_seg) begin failures++; $display("FAIL scan_sseg k=%0d got=%h exp=%h", k, sseg, exp_seg); end
            checks++; if (digit_idx !== exp_digit) begin failures++; $display("FAIL scan_digit k=%0d got=%0d exp=%0d", k, digit_idx, exp_digit); end
            checks++; if (frame_tick !== exp_ft) begin failures++; $display("FAIL scan_ft k=%0d got=%b exp=%b", k, frame_tick, exp_ft); end
        end
        checks++; if (ft_count != 2) begin failures++; $display("FAIL scan_ft_count got=%0d exp=2", ft_count); end
    endtask

    task automatic test_mid_slot_change();
        int f0;
        logic [7:0] want;
        s1 = 8'hA4;
        f0 = k / 64;
        while (k < (f0 + 2) * 64) begin
            if (((k / SLOT) % 4 == 1) && (k % SLOT == 8) && (k / 64 == f0)) s1 = 8'h99;
            tick();
            if (((k / SLOT) % 4 == 1) && (k % SLOT >= BC)) begin
                want = (k / 64 == f0) ? 8'hA4 : 8'h99;
                checks++; if (sseg !== want) begin failures++; $display("FAIL midslot_sseg k=%0d got=%h exp=%h", k, sseg, want); end
            end
            checks++; if (an !== exp_an) begin failures++; $display("FAIL midslot_an k=%0d got=%b exp=%b", k, an, exp_an); end
        end
    endtask

    task automatic test_en();
        s0 = 8'hC0; s1 = 8'hF9; s2 = 8'hA4; s3 = 8'hB0; en = 1'b1;
        do_reset();
        for (int i = 0; i < 128; i++) begin
            if (k == 5) en = 1'b0;
            if (k == 41) en = 1'b1;
            tick();
            if (k >= 6 && k <= 41) begin
                checks++; if (an !== 4'b1111 || sseg !== 8'hFF) begin failures++; $display("FAIL en_blank k=%0d got=%b/%h exp=1111/ff", k, an, sseg); end
            end
            checks++; if (an !== exp_an) begin failures++; $display("FAIL en_an k=%0d got=%b exp=%b", k, an, exp_an); end
            checks++; if (sseg !== exp_seg) begin failures++; $display("FAIL en_sseg k=%0d got=%h exp=%h", k, sseg, exp_seg); end
            checks++; if (digit_idx !== exp_digit) begin failures++; $display("FAIL en_digit k=%0d got=%0d exp=%0d", k, digit_idx, exp_digit); end
            checks++; if (frame_tick !== exp_ft) begin failures++; $display("FAIL en_ft k=%0d got=%b exp=%b", k, frame_tick, exp_ft); end
        end
    endtask

    task automatic test_random_frames();
        int         off_run = BC;
        logic [3:0] last_lit = 4'b1111;
        en = 1'b1;
        do_reset();
        for (int i = 0; i < 1000 * 64; i++) begin
            if ($urandom_range(7) == 0) begin
                case ($urandom_range(3))
                    0: s0 = 8'($urandom);
                    1: s1 = 8'($urandom);
                    2: s2 = 8'($urandom);
                    default: s3 = 8'($urandom);
                endcase
            end
            if ($urandom_range(63) == 0) en = ~en;
            tick();
            checks++; if (an !== exp_an) begin failures++; $display("FAIL rand_an k=%0d got=%b exp=%b", k, an, exp_an); end
            checks++; if (sseg !== exp_seg) begin failures++; $display("FAIL rand_sseg k=%0d got=%h exp=%h", k, sseg, exp_seg); end
            checks++; if ($countones(~an) > 1) begin failures++; $display("FAIL rand_onehot k=%0d got=%b exp=at_most_one_low", k, an); end
            if (an === 4'b1111) begin
                off_run++;
            end else begin
                if (last_lit !== 4'b1111 && an !== last_lit) begin
                    checks++; if (off_run < BC) begin failures++; $display("FAIL rand_gap k=%0d got=%0d exp>=%0d", k, off_run, BC); end
                end
                last_lit = an;
                off_run = 0;
            end
        end
        en = 1'b1;
    endtask

    task automatic test_reset_mid_slot();
        s0 = 8'hC0; s1 = 8'hF9; s2 = 8'hA4; s3 = 8'hB0; en = 1'b1;
        do_reset();
        while (!(((k / SLOT) % 4 == 2) && (k % SLOT == 7))) begin
            tick();
            checks++; if (an !== exp_an) begin failures++; $display("FAIL rstmid_pre_an k=%0d got=%b exp=%b", k, an, exp_an); end
        end
        checks++; if (an !== 4'b1011) begin failures++; $display("FAIL rstmid_lit got=%b exp=1011", an); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (an !== 4'b1111 || sseg !== 8'hFF) begin failures++; $display("FAIL rstmid_async got=%b/%h exp=1111/ff", an, sseg); end
        checks++; if (digit_idx !== 2'd0) begin failures++; $display("FAIL rstmid_digit got=%0d exp=0", digit_idx); end
        @(negedge clk);
        reset_n = 1'b1;
        k = 0;
        tick();
        checks++; if (an !== 4'b1111) begin failures++; $display("FAIL rstmid_c1 got=%b exp=1111", an); end
        tick();
        checks++; if (an !== 4'b1110 || sseg !== 8'hC0) begin failures++; $display("FAIL rstmid_c2 got=%b/%h exp=1110/c0", an, sseg); end
    endtask

`ifdef SSEG_SCAN_DIM_EN
    task automatic test_dim();
        int lit_cnt;
        int lit_max;
        en = 1'b1;
        duty = 4'd0;
        do_reset();
        lit_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (an !== 4'b1111) lit_cnt++;
            checks++; if (an !== exp_an) begin failures++; $display("FAIL dim0_an k=%0d got=%b exp=%b", k, an, exp_an); end
        end
        checks++; if (lit_cnt != 0) begin failures++; $display("FAIL dim0_count got=%0d exp=0", lit_cnt); end
        duty = 4'd7;
        lit_cnt = 0;
        lit_max = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (an !== 4'b1111) begin
                lit_cnt++;
                if (k % SLOT > lit_max) lit_max = k % SLOT;
            end
            checks++; if (an !== exp_an) begin failures++; $display("FAIL dim7_an k=%0d got=%b exp=%b", k, an, exp_an); end
            checks++; if (sseg !== exp_seg) begin failures++; $display("FAIL dim7_sseg k=%0d got=%h exp=%h", k, sseg, exp_seg); end
        end
        checks++; if (lit_cnt != 24) begin failures++; $display("FAIL dim7_count got=%0d exp=24", lit_cnt); end
        checks++; if (lit_max != 7) begin failures++; $display("FAIL dim7_last got=%0d exp=7", lit_max); end
        duty = 4'd15;
    endtask
`endif

    initial begin
        test_reset();
        test_scan();
        test_mid_slot_change();
        test_en();
        test_random_frames();
        test_reset_mid_slot();
`ifdef SSEG_SCAN_DIM_EN
        test_dim();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sseg_scan_mux.md
Name: sseg_scan_mux

Overview:
- Time-multiplexed driver for a 4-digit common-anode 7-segment display.
- Consumes per-digit segment patterns from the BCD-to-7seg decode stage (sseg0..sseg2, with sseg3 as a spare digit) and drives the shared segment bus plus one-hot active-low anodes.
- Sits between the decode stage and the board pins.
- Inserts a blanking interval between digits to suppress ghosting.

Parameters:
- REFRESH_BITS, 16: width of the slot counter. Each digit slot lasts 2^REFRESH_BITS clk cycles.
- BLANK_CYCLES, 64: cycles at the start of each slot during which all anodes are off. Legal range 1 .. 2^REFRESH_BITS-2.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- en  in  1  display enable. When 0, outputs are blanked; the scan keeps running.
- sseg0  in  8  segment pattern, digit 0 (ones), {dp,g..a}, active-low
- sseg1  in  8  digit 1 (tens)
- sseg2  in  8  digit 2 (hundreds)
- sseg3  in  8  digit 3 (spare; tie 8'hFF if unused)
- an  out  4  anode enables, active-low, at most one bit low
- sseg  out  8  segment bus, active-low
- digit_idx  out  2  digit currently owning the slot
- frame_tick  out  1  one-cycle pulse at the end of digit 3's slot

Behaviour:
- Reset is asynchronous and active-low; the block runs on the single clock clk. During and after reset:
  - cnt = 0, digit_idx = 0, state = ST_BLANK
  - an = 4'b1111, sseg = 8'hFF, frame_tick = 0, latched pattern = 8'hFF
- Slot counter cnt:
  - REFRESH_BITS wide, increments every cycle and wraps naturally.
  - On wrap (cnt == all-ones), digit_idx advances 0->1->2->3->0.
  - frame_tick = 1 in the cycle cnt wraps while digit_idx == 3 (registered, aligned with the wrap).
- FSM:
  - ST_BLANK: while cnt < BLANK_CYCLES. Registered outputs are an = 1111, sseg = FF.
  - Transition ST_BLANK -> ST_DRIVE when cnt == BLANK_CYCLES-1. In that same edge, the pattern sseg[digit_idx] is captured into the latched pattern.
  - ST_DRIVE: an = ~(1 << digit_idx), sseg = latched pattern.
  - Transition ST_DRIVE -> ST_BLANK on cnt wrap.
- Input latching: the inputs are sampled exactly once per slot. Input changes mid-slot are invisible until the next slot.
- Latency: an/sseg are registered. The first lit cycle of a slot is the cycle in which cnt == BLANK_CYCLES.
- en:
  - en = 0 forces an = 1111 and sseg = FF from the next clk edge.
  - cnt, digit_idx, FSM and frame_tick continue unaffected.
  - en rising mid-DRIVE lights the current digit from the next edge, using that slot's latched pattern.
- Invariants:
  - an is never multi-hot.
  - an and sseg change on the same edge.
  - No lit cycle spans a digit change; the blank interval always separates slots.
- Reset mid-slot returns immediately (asynchronously) to the reset values; the scan restarts at digit 0, cnt = 0.

Optional Feature:
- Macro: SSEG_SCAN_DIM_EN
- With the macro defined:
  - Extra input port duty [3:0].
  - In ST_DRIVE, the digit is lit only when cnt[REFRESH_BITS-1 -: 4] <= duty; otherwise an = 1111, sseg = FF.
  - duty = 15 gives the full drive phase.
  - duty is sampled together with the pattern at the ST_BLANK->ST_DRIVE edge.
  - Requires REFRESH_BITS >= 4.
- Without the macro: port absent; lit for the whole ST_DRIVE phase.

Decomposition:
- Package sseg_scan_pkg:
  - state enum {ST_BLANK, ST_DRIVE}
  - NUM_DIGITS = 4
  - AN_OFF = 4'b1111
  - SEG_OFF = 8'hFF
- Sub-module sseg_refresh_timer: slot counter, digit_idx sequencing, wrap and frame_tick generation; exports cnt and a wrap strobe.
- Top level contains the FSM, pattern latch, anode decode and output registers.

Test Plan:
All scenarios use REFRESH_BITS = 4 and BLANK_CYCLES = 2.
- Reset release: sseg0..3 = C0, F9, A4, B0.
  - Cycles 0-1: an = 1111.
  - Cycles 2-15: an = 1110, sseg = C0.
  - Then an = 1101 / F9, 1011 / A4, 0111 / B0.
  - frame_tick pulses once per 64 cycles.
- Mid-slot change: sseg1 changes A4->99 at cnt = 8 of slot 1 -> sseg stays A4 until slot 1 of the next frame, which shows 99.
- Blank gap: across every digit transition, at least 2 consecutive cycles of an = 1111. an is never two-hot over 1000 frames.
- en: en = 0 for cycles 5-40 -> an = 1111 and sseg = FF in cycles 6-41. digit_idx and frame_tick timing are identical to the en = 1 run.
- Reset mid-slot: assert reset_n = 0 at cnt = 7 of digit 2 -> an = 1111, sseg = FF without waiting for clk; after release, digit 0 lights at cycle 2.
- With SSEG_SCAN_DIM_EN:
  - duty = 0 -> lit only for cnt = 2..15 where cnt[3:0] <= 0, i.e. never lit (0 lit cycles).
  - duty = 7 -> lit for cnt = 2..7 only.
